// File: rtl/serv_ibus_resp_if.sv
// Purpose : instruction-fetch bus plus synchronous-read memory port of serv_ibus_resp.
// Latency : n/a (signal bundle only).
// Backpressure: core holds i_ibus_cyc until o_ibus_ack; the memory port is never stalled.
// Ports   : i_ibus_* / o_ibus_* / o_fault fetch side, i_inval fence.i, o_mem_* / i_mem_rdata memory side.
interface serv_ibus_resp_if #(
  parameter int AW = 10
);
  logic [31:0]   i_ibus_adr;
  logic          i_ibus_cyc;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;
  logic          o_fault;
  logic          i_inval;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_adr;
  logic [31:0]   i_mem_rdata;

  // slave: the fetch responder
  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_inval, i_mem_rdata,
    output o_ibus_rdt, o_ibus_ack, o_fault, o_mem_en, o_mem_adr
  );

  // master: core plus memory around the responder
  modport master (
    output i_ibus_adr, i_ibus_cyc, i_inval, i_mem_rdata,
    input  o_ibus_rdt, o_ibus_ack, o_fault, o_mem_en, o_mem_adr
  );
endinterface

// File: rtl/serv_ibus_resp.sv
// Purpose : answers SERV instruction fetches from a sync-read memory window, with a one-entry last-fetch buffer.
// Latency : fault/hit ack 1 cycle after accept; aligned miss 2, halfword-straddling miss 3; misses add WAIT.
// Backpressure: none; dropping i_ibus_cyc mid-read aborts without ack. Ports: clk, i_rst_n, bus (slave modport).
module serv_ibus_resp #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter int          WAIT = 0
) (
  input  logic            clk,
  input  logic            i_rst_n,
  serv_ibus_resp_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WAITS, ACK} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t        state;
  logic [31:1]   adr_q;
  logic [31:0]   res_q;
  logic [3:0]    cnt_q;
  logic          miss_q;
  logic          gap_q;      // the cycle right after ACK ignores cyc
  logic          ack_q;
  logic [31:0]   rdt_q;
  logic          fault_q;
  logic          buf_vld;
  logic [31:1]   buf_tag;
  logic [31:0]   buf_dat;

  logic          adr_fault;
  logic          buf_hit;
  logic          accept;
  logic [31:0]   rd_word;
  logic          mem_en;
  logic [AW-1:0] mem_adr;

  assign adr_fault = bus.i_ibus_adr[0] |
                     (bus.i_ibus_adr[31:AW+2] != BASE[31:AW+2]);
  assign buf_hit   = buf_vld && (buf_tag == bus.i_ibus_adr[31:1]);
  assign accept    = (state == IDLE) && bus.i_ibus_cyc && !gap_q;

  // Second half of a straddling fetch lands in the upper result halfword.
  assign rd_word = (state == RD1) ? {bus.i_mem_rdata[15:0], res_q[15:0]}
                                  : bus.i_mem_rdata;

  always_comb begin
    mem_en  = 1'b0;
    mem_adr = '0;
    if (i_rst_n) begin
      if (accept && !adr_fault && !buf_hit) begin
        mem_en  = 1'b1;
        mem_adr = bus.i_ibus_adr[AW+1:2];
      end else if ((state == RD0) && bus.i_ibus_cyc && adr_q[1]) begin
        // Next word wraps around the top of the window.
        mem_en  = 1'b1;
        mem_adr = adr_q[AW+1:2] + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      adr_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
      gap_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      fault_q <= 1'b0;
      buf_vld <= 1'b0;
      buf_tag <= '0;
      buf_dat <= '0;
    end else begin
      ack_q   <= 1'b0;
      rdt_q   <= '0;
      fault_q <= 1'b0;
      gap_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            adr_q  <= bus.i_ibus_adr[31:1];
            miss_q <= 1'b0;
            if (adr_fault) begin
              state   <= ACK;
              ack_q   <= 1'b1;
              fault_q <= 1'b1;
            end else if (buf_hit) begin
              state <= ACK;
              ack_q <= 1'b1;
              rdt_q <= buf_dat;
            end else begin
              state  <= RD0;
              miss_q <= 1'b1;
            end
          end
        end
        RD0, RD1: begin
          if (!bus.i_ibus_cyc) begin
            state <= IDLE;
          end else if ((state == RD0) && adr_q[1]) begin
            res_q[15:0] <= bus.i_mem_rdata[31:16];
            state       <= RD1;
          end else begin
            res_q <= rd_word;
            if (WAIT > 0) begin
              cnt_q <= WAIT_CNT;
              state <= WAITS;
            end else begin
              state <= ACK;
              ack_q <= 1'b1;
              rdt_q <= rd_word;
            end
          end
        end
        WAITS: begin
          if (!bus.i_ibus_cyc) begin
            state <= IDLE;
            cnt_q <= '0;
          end else if (cnt_q <= 4'd1) begin
            cnt_q <= '0;
            state <= ACK;
            ack_q <= 1'b1;
            rdt_q <= res_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state <= IDLE;
          gap_q <= 1'b1;
          if (miss_q) begin
            buf_vld <= 1'b1;
            buf_tag <= adr_q;
            buf_dat <= rdt_q;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a same-edge invalidate beats the buffer load.
      if (bus.i_inval) buf_vld <= 1'b0;
    end
  end

  assign bus.o_ibus_ack = ack_q;
  assign bus.o_ibus_rdt = rdt_q;
  assign bus.o_fault    = fault_q;
  assign bus.o_mem_en   = mem_en;
  assign bus.o_mem_adr  = mem_adr;

endmodule

// File: tb/tb_serv_ibus_resp.sv
// Purpose : directed bench for serv_ibus_resp: WAIT=0 and WAIT=3 instances on one shared memory image.
// Latency : measured from the accepting cycle to the ack cycle.
// Backpressure: bench holds cyc until ack, then drops it for at least one cycle.
module tb_serv_ibus_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, inval, sel;
  logic [31:0] adr;
  logic [31:0] rdata0, rdata3;
  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  serv_ibus_resp_if #(.AW(10)) if0 ();
  serv_ibus_resp_if #(.AW(10)) if3 ();

  assign if0.i_ibus_adr  = adr;
  assign if3.i_ibus_adr  = adr;
  assign if0.i_ibus_cyc  = cyc && !sel;
  assign if3.i_ibus_cyc  = cyc && sel;
  assign if0.i_inval     = inval;
  assign if3.i_inval     = inval;
  assign if0.i_mem_rdata = rdata0;
  assign if3.i_mem_rdata = rdata3;

  serv_ibus_resp #(.AW(10), .BASE(32'h0), .WAIT(0)) dut0 (
    .clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
  serv_ibus_resp #(.AW(10), .BASE(32'h0), .WAIT(3)) dut3 (
    .clk(clk), .i_rst_n(rst_n), .bus(if3.slave));

  always @(posedge clk) begin
    if (if0.o_mem_en) rdata0 <= mem[if0.o_mem_adr];
    if (if3.o_mem_en) rdata3 <= mem[if3.o_mem_adr];
  end

  wire        m_ack   = sel ? if3.o_ibus_ack : if0.o_ibus_ack;
  wire [31:0] m_rdt   = sel ? if3.o_ibus_rdt : if0.o_ibus_rdt;
  wire        m_fault = sel ? if3.o_fault    : if0.o_fault;
  wire        m_en    = sel ? if3.o_mem_en   : if0.o_mem_en;
  wire [9:0]  m_madr  = sel ? if3.o_mem_adr  : if0.o_mem_adr;

  typedef struct {
    logic [31:0] adr;
    logic        inval;
    int          lat;
    logic [31:0] rdt;
    logic        flt;
    int          nrd;
    logic [9:0]  a0;
    logic [9:0]  a1;
  } vec_t;

  vec_t vt [12];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Samples at the falling edge; i==0 is the accepting cycle.
  task automatic measure(output int lat, output logic [31:0] rdt, output logic flt,
                         output int nrd, output logic [9:0] a0, output logic [9:0] a1,
                         output logic zok, output logic ack_after);
    lat = -1; rdt = '0; flt = 1'b0; nrd = 0; a0 = '0; a1 = '0; zok = 1'b1; ack_after = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_en) begin
        if (nrd == 0) a0 = m_madr; else a1 = m_madr;
        nrd++;
      end
      if (m_ack) begin
        lat = i; rdt = m_rdt; flt = m_fault;
        break;
      end
      if (m_rdt !== 32'h0 || m_fault !== 1'b0) zok = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cyc = 1'b0;
    @(negedge clk);
    ack_after = m_ack;
  endtask

  task automatic verify(input string nm, input vec_t e);
    int lat, nrd;
    logic [31:0] rdt;
    logic flt, zok, aa;
    logic [9:0] a0, a1;
    measure(lat, rdt, flt, nrd, a0, a1, zok, aa);
    chk({nm, " latency"}, 32'(lat), 32'(e.lat));
    chk({nm, " rdt"}, rdt, e.rdt);
    chk({nm, " fault"}, {31'b0, flt}, {31'b0, e.flt});
    chk({nm, " mem reads"}, 32'(nrd), 32'(e.nrd));
    if (e.nrd > 0) chk({nm, " first mem adr"}, {22'b0, a0}, {22'b0, e.a0});
    if (e.nrd > 1) chk({nm, " second mem adr"}, {22'b0, a1}, {22'b0, e.a1});
    chk({nm, " rdt/fault zero without ack"}, {31'b0, zok}, 32'd1);
    chk({nm, " single-cycle ack"}, {31'b0, aa}, 32'd0);
  endtask

  task automatic run_fetch(input string nm, input logic s, input vec_t e);
    if (e.inval) begin
      @(posedge clk); #1;
      inval = 1'b1;
      @(posedge clk); #1;
      inval = 1'b0;
    end
    @(posedge clk); #1;
    sel = s; adr = e.adr; cyc = 1'b1;
    verify(nm, e);
  endtask

  initial begin
    vec_t e;
    logic seen;

    // adr, inval, lat, rdt, fault, nrd, a0, a1
    vt[0]  = '{32'h0000_0010, 1'b0, 2, 32'h00A0_0093, 1'b0, 1, 10'd4,    10'd0};
    vt[1]  = '{32'h0000_0010, 1'b0, 1, 32'h00A0_0093, 1'b0, 0, 10'd0,    10'd0};
    vt[2]  = '{32'h0000_0010, 1'b1, 2, 32'h00A0_0093, 1'b0, 1, 10'd4,    10'd0};
    vt[3]  = '{32'h0000_0011, 1'b0, 1, 32'h0000_0000, 1'b1, 0, 10'd0,    10'd0};
    vt[4]  = '{32'h0000_1000, 1'b0, 1, 32'h0000_0000, 1'b1, 0, 10'd0,    10'd0};
    vt[5]  = '{32'h8000_0010, 1'b0, 1, 32'h0000_0000, 1'b1, 0, 10'd0,    10'd0};
    vt[6]  = '{32'h0000_0010, 1'b0, 1, 32'h00A0_0093, 1'b0, 0, 10'd0,    10'd0};
    vt[7]  = '{32'h0000_0012, 1'b0, 3, 32'hDEF0_00A0, 1'b0, 2, 10'd4,    10'd5};
    vt[8]  = '{32'h0000_0012, 1'b0, 1, 32'hDEF0_00A0, 1'b0, 0, 10'd0,    10'd0};
    vt[9]  = '{32'h0000_0FFE, 1'b0, 3, 32'h2222_3333, 1'b0, 2, 10'd1023, 10'd0};
    vt[10] = '{32'h0000_0000, 1'b0, 2, 32'h1111_2222, 1'b0, 1, 10'd0,    10'd0};
    vt[11] = '{32'h0000_0002, 1'b0, 3, 32'h6666_1111, 1'b0, 2, 10'd0,    10'd1};

    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 ^ 32'(i);
    mem[0]    = 32'h1111_2222;
    mem[1]    = 32'h5555_6666;
    mem[4]    = 32'h00A0_0093;
    mem[5]    = 32'h9ABC_DEF0;
    mem[8]    = 32'h0BAD_F00D;
    mem[1023] = 32'h3333_4444;

    rst_n = 1'b0; cyc = 1'b0; inval = 1'b0; sel = 1'b0; adr = '0;

    // Reset state, including a request held during reset.
    @(negedge clk);
    chk("reset ack",   {31'b0, if0.o_ibus_ack}, 32'd0);
    chk("reset fault", {31'b0, if0.o_fault},    32'd0);
    chk("reset rdt",   if0.o_ibus_rdt,          32'd0);
    cyc = 1'b1; adr = 32'h10;
    @(negedge clk);
    chk("reset mem_en wait0", {31'b0, if0.o_mem_en}, 32'd0);
    sel = 1'b1;
    #1;
    chk("reset mem_en wait3", {31'b0, if3.o_mem_en}, 32'd0);
    cyc = 1'b0; sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_fetch($sformatf("vec%0d", i), 1'b0, vt[i]);

    // Reset while in RD0: no ack, buffer dropped, next edge accepts with no gap.
    @(posedge clk); #1;
    sel = 1'b0; adr = 32'h10; cyc = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset ack",    {31'b0, if0.o_ibus_ack}, 32'd0);
    chk("midreset mem_en", {31'b0, if0.o_mem_en},   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; adr = 32'h2;
    verify("post-reset refetch", vt[11]);

    // WAIT=3 abort: cyc drops at N+3, no ack and buffer stays empty.
    @(posedge clk); #1;
    sel = 1'b1; adr = 32'h10; cyc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_ack) seen = 1'b1;
    end
    chk("wait3 abort ack", {31'b0, seen}, 32'd0);

    e = '{32'h10, 1'b0, 5, 32'h00A0_0093, 1'b0, 1, 10'd4, 10'd0};
    run_fetch("wait3 miss", 1'b1, e);
    e = '{32'h10, 1'b0, 1, 32'h00A0_0093, 1'b0, 0, 10'd0, 10'd0};
    run_fetch("wait3 hit", 1'b1, e);
    e = '{32'h12, 1'b0, 6, 32'hDEF0_00A0, 1'b0, 2, 10'd4, 10'd5};
    run_fetch("wait3 straddle", 1'b1, e);

    // Invalidate during the ACK cycle beats the buffer load.
    @(posedge clk); #1;
    sel = 1'b0; adr = 32'h20; cyc = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inval = 1'b1;
    @(negedge clk);
    chk("inval-vs-load ack", {31'b0, m_ack}, 32'd1);
    chk("inval-vs-load rdt", m_rdt, 32'h0BAD_F00D);
    @(posedge clk); #1;
    inval = 1'b0; cyc = 1'b0;
    e = '{32'h20, 1'b0, 2, 32'h0BAD_F00D, 1'b0, 1, 10'd8, 10'd0};
    run_fetch("after inval-vs-load", 1'b0, e);

    // Straddle with the reference data words.
    mem[4] = 32'h1234_5678;
    e = '{32'h12, 1'b1, 3, 32'hDEF0_1234, 1'b0, 2, 10'd4, 10'd5};
    run_fetch("straddle ref", 1'b0, e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serv_ibus_resp.md
SERV_IBUS_RESP -- requirements
Module: serv_ibus_resp

Interface
REQ-001 SHALL have parameter AW, default 10, memory word-address width (window = 2^(AW+2) bytes).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, window base byte address; bits [AW+1:0] ignored.
REQ-003 SHALL have parameter WAIT, default 0, extra wait cycles (0-15) inserted before every memory-served ack.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_ibus_adr  input  32  fetch byte address from the core, halfword-aligned.
REQ-007 SHALL have port i_ibus_cyc  input  1  fetch request; held until ack.
REQ-008 SHALL have port o_ibus_rdt  output  32  fetched instruction, valid while o_ibus_ack=1.
REQ-009 SHALL have port o_ibus_ack  output  1  one-cycle fetch completion.
REQ-010 SHALL have port o_fault  output  1  fetch fault, valid only with o_ibus_ack.
REQ-011 SHALL have port i_inval  input  1  invalidate last-fetch buffer (fence.i).
REQ-012 SHALL have port o_mem_en  output  1  synchronous-read memory enable.
REQ-013 SHALL have port o_mem_adr  output  AW  memory word address.
REQ-014 SHALL have port i_mem_rdata  input  32  memory data, valid the cycle after o_mem_en.

Function
REQ-015 SHALL implement states IDLE, RD0, RD1, WAITS, ACK.
REQ-016 IDLE: SHALL accept a request when i_ibus_cyc=1, except in the cycle immediately after ACK, where cyc SHALL be ignored.
REQ-017 Fault: adr[0]=1 or adr[31:AW+2]!=BASE[31:AW+2] SHALL skip memory, go to ACK; ack next cycle with rdt=0, o_fault=1.
REQ-018 Hit: buffer valid and tag==adr[31:1] SHALL skip memory, go to ACK; ack next cycle with buffered data, o_fault=0.
REQ-019 Miss: SHALL drive o_mem_en=1, o_mem_adr=adr[AW+1:2] combinationally in the accepting IDLE cycle, then go to RD0.
REQ-020 RD0, adr[1]=0: SHALL capture i_mem_rdata as the full word.
REQ-021 RD0, adr[1]=1: SHALL capture rdata[31:16] as result[15:0], issue o_mem_en with o_mem_adr=(word+1) mod 2^AW, go to RD1.
REQ-022 RD1: SHALL capture rdata[15:0] as result[31:16].
REQ-023 After RD0/RD1 SHALL go to WAITS when WAIT>0 (count WAIT cycles), else directly to ACK.
REQ-024 ACK: o_ibus_ack=1 for exactly one cycle, registered output; then IDLE.
REQ-025 Latency, accept in cycle N, WAIT=0: fault/hit ack at N+1; aligned miss N+2; straddling miss N+3; misses add WAIT.
REQ-026 On a non-fault miss ack SHALL load buffer with result and tag=adr[31:1], set valid.
REQ-027 i_inval=1 SHALL clear valid next edge; simultaneous with buffer load, invalidate wins.
REQ-028 i_ibus_cyc=0 in RD0/RD1/WAITS SHALL abort to IDLE: no ack, no buffer update, returned data discarded.
REQ-029 o_mem_en SHALL be 0 in all states other than those in REQ-019/REQ-021.
REQ-030 o_ibus_rdt and o_fault SHALL be 0 whenever o_ibus_ack=0.

Reset
REQ-031 i_rst_n=0 SHALL immediately force IDLE, o_ibus_ack=0, o_fault=0, o_ibus_rdt=0, o_mem_en=0, buffer invalid, wait counter 0.
REQ-032 Reset mid-transaction SHALL drop it with no ack; first edge after release SHALL behave as IDLE with no post-ack gap.

Verification
REQ-033 Aligned miss: BASE=0, mem[4]=32'h00A00093, adr=0x10, WAIT=0 -> mem_en/adr=4 at N, ack at N+2, rdt=32'h00A00093, fault=0.
REQ-034 Straddle: mem[4]=32'h1234_5678, mem[5]=32'h9ABC_DEF0, adr=0x12 -> reads 4 then 5, ack at N+3, rdt=32'hDEF0_1234.
REQ-035 Hit/invalidate: repeat adr=0x10 -> ack N+1, no mem_en; pulse i_inval, repeat -> mem_en issued, ack N+2.
REQ-036 Faults: adr=0x11 and adr=0x0000_1000 (AW=10) -> ack N+1, rdt=0, fault=1, no mem_en.
REQ-037 WAIT=3, aligned miss -> ack N+5; deassert cyc at N+3 in another run -> no ack, buffer still invalid.
REQ-038 Wrap: adr=0xFFE (AW=10) -> second read at o_mem_adr=0, rdt={mem[0][15:0], mem[1023][31:16]}.
